// File: rtl/regfile_writeback_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_writeback_arbiter_if
//   Bundles the result-stream handshakes, the scoreboard reserve request and
//   the register-file write port of regfile_writeback_arbiter.
//
//   alu_valid_i/alu_ready_o/alu_addr_i/alu_data_i   ALU result stream
//   mem_valid_i/mem_ready_o/mem_addr_i/mem_data_i   load result stream
//   reserve_en_i/reserve_addr_i                     issue marks a register pending
//   address_3_o/wr_data_o/wr_en_o                   register-file write port
//   pending_o                                       pending-write scoreboard
//
//   Modports: slave = the arbiter, master = the surrounding pipeline.
// ---------------------------------------------------------------------------
interface regfile_writeback_arbiter_if #(
    parameter int REG_COUNT = 32,
    parameter int REG_WIDTH = 32
);
    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic                 alu_valid_i;
    logic                 alu_ready_o;
    logic [AW-1:0]        alu_addr_i;
    logic [REG_WIDTH-1:0] alu_data_i;

    logic                 mem_valid_i;
    logic                 mem_ready_o;
    logic [AW-1:0]        mem_addr_i;
    logic [REG_WIDTH-1:0] mem_data_i;

    logic                 reserve_en_i;
    logic [AW-1:0]        reserve_addr_i;

    logic [AW-1:0]        address_3_o;
    logic [REG_WIDTH-1:0] wr_data_o;
    logic                 wr_en_o;
    logic [REG_COUNT-1:0] pending_o;

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  mem_valid_i, mem_addr_i, mem_data_i,
        input  reserve_en_i, reserve_addr_i,
        output alu_ready_o, mem_ready_o,
        output address_3_o, wr_data_o, wr_en_o, pending_o
    );

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output mem_valid_i, mem_addr_i, mem_data_i,
        output reserve_en_i, reserve_addr_i,
        input  alu_ready_o, mem_ready_o,
        input  address_3_o, wr_data_o, wr_en_o, pending_o
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_writeback_arbiter
//   Write-side front end of the register file. ALU and load results each
//   enter a small FIFO; a round-robin arbiter drains one entry per cycle onto
//   the registered write port. A one-bit-per-register scoreboard tracks
//   writes that issue has reserved but that have not reached the port yet.
//
//   clk_i    clock
//   reset_i  asynchronous, active-high reset
//   bus      regfile_writeback_arbiter_if.slave (streams, reserve, write port,
//            scoreboard)
// ---------------------------------------------------------------------------
module regfile_writeback_arbiter #(
    parameter int REG_COUNT          = 32,
    parameter int REG_WIDTH          = 32,
    parameter int FIFO_DEPTH         = 2,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    regfile_writeback_arbiter_if.slave  bus
);

    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    // Source index 0 is the ALU, index 1 the load unit.
    typedef enum logic { RR_ALU = 1'b0, RR_MEM = 1'b1 } rr_e;

    typedef struct packed {
        logic [AW-1:0]        addr;
        logic [REG_WIDTH-1:0] data;
    } entry_t;

    entry_t               fifo_q [2][FIFO_DEPTH];
    entry_t               fifo_d [2][FIFO_DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [PW:0]          wr_ptr_q [2];
    logic [PW:0]          wr_ptr_d [2];
    logic [PW:0]          rd_ptr_q [2];
    logic [PW:0]          rd_ptr_d [2];
    rr_e                  rr_q, rr_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        address_3_q, address_3_d;
    logic [REG_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [REG_COUNT-1:0] pending_q, pending_d;

    logic [1:0]           nonempty;
    logic [1:0]           full;
    logic [1:0]           push;
    logic [1:0]           grant;
    logic                 alu_ready;
    logic                 mem_ready;
    entry_t               push_entry [2];
    entry_t               head;
    logic                 head_in_range;
    logic                 head_writable;

    // ---- FIFO status and input handshake ----
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            nonempty[s] = (wr_ptr_q[s] != rd_ptr_q[s]);
            full[s]     = (wr_ptr_q[s][PW] != rd_ptr_q[s][PW]) &&
                          (wr_ptr_q[s][PW-1:0] == rd_ptr_q[s][PW-1:0]);
        end
    end

    // Ready looks only at fullness: a pop in the same cycle does not free a
    // slot for the incoming entry until the following cycle.
    assign alu_ready = !full[0] && !reset_i;
    assign mem_ready = !full[1] && !reset_i;

    assign push[0] = bus.alu_valid_i && alu_ready;
    assign push[1] = bus.mem_valid_i && mem_ready;

    assign push_entry[0] = '{addr: bus.alu_addr_i, data: bus.alu_data_i};
    assign push_entry[1] = '{addr: bus.mem_addr_i, data: bus.mem_data_i};

    // ---- Arbitration: round robin only matters when both sources wait ----
    always_comb begin
        grant[0] = nonempty[0] && (!nonempty[1] || rr_q == RR_ALU);
        grant[1] = nonempty[1] && (!nonempty[0] || rr_q == RR_MEM);
        head     = grant[1] ? fifo_q[1][rd_ptr_q[1][PW-1:0]]
                            : fifo_q[0][rd_ptr_q[0][PW-1:0]];

        // Equality scan keeps the range test valid for non-power-of-two counts.
        head_in_range = 1'b0;
        for (int r = 0; r < REG_COUNT; r++) begin
            if (head.addr == AW'(r)) begin
                head_in_range = 1'b1;
            end
        end
        head_writable = (|grant) && head_in_range &&
                        !(ZERO_REG_HARDWIRED && head.addr == '0);
    end

    // ---- Next state: FIFOs, pointer, write port, scoreboard ----
    always_comb begin
        fifo_d = fifo_q;
        for (int s = 0; s < 2; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s];
            rd_ptr_d[s] = rd_ptr_q[s];
            if (push[s]) begin
                fifo_d[s][wr_ptr_q[s][PW-1:0]] = push_entry[s];
                wr_ptr_d[s] = wr_ptr_q[s] + (PW+1)'(1);
            end
            // Every granted entry is consumed, writable or not.
            if (grant[s]) begin
                rd_ptr_d[s] = rd_ptr_q[s] + (PW+1)'(1);
            end
        end

        rr_d = rr_q;
        if (&nonempty) begin
            rr_d = grant[0] ? RR_MEM : RR_ALU;
        end

        wr_en_d     = head_writable;
        address_3_d = address_3_q;
        wr_data_d   = wr_data_q;
        if (head_writable) begin
            address_3_d = head.addr;
            wr_data_d   = head.data;
        end

        // Clear first, then set, so a same-edge reserve of the register
        // being written keeps it pending.
        pending_d = pending_q;
        for (int r = 0; r < REG_COUNT; r++) begin
            if (head_writable && head.addr == AW'(r)) begin
                pending_d[r] = 1'b0;
            end
            if (bus.reserve_en_i && bus.reserve_addr_i == AW'(r) &&
                !(ZERO_REG_HARDWIRED && r == 0)) begin
                pending_d[r] = 1'b1;
            end
        end
    end

    // ---- Registers: control and write port ----
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
            end
            rr_q        <= RR_ALU;
            wr_en_q     <= 1'b0;
            address_3_q <= '0;
            wr_data_q   <= '0;
            pending_q   <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
            end
            rr_q        <= rr_d;
            wr_en_q     <= wr_en_d;
            address_3_q <= address_3_d;
            wr_data_q   <= wr_data_d;
            pending_q   <= pending_d;
        end
    end

    // ---- Registers: FIFO storage (contents are qualified by the pointers) ----
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

    assign bus.alu_ready_o = alu_ready;
    assign bus.mem_ready_o = mem_ready;
    assign bus.address_3_o = address_3_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.wr_en_o     = wr_en_q;
    assign bus.pending_o   = pending_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;

    localparam int DEPTH = 2;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    regfile_writeback_arbiter_if #(.REG_COUNT(32), .REG_WIDTH(32)) bus ();

    regfile_writeback_arbiter #(
        .REG_COUNT(32), .REG_WIDTH(32), .FIFO_DEPTH(DEPTH), .ZERO_REG_HARDWIRED(1'b1)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        aq[$];
    ent_t        mq[$];
    bit          m_rr_mem = 1'b0;   // 1: load unit wins the next contested grant
    logic        e_wen = 1'b0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    logic [31:0] e_pend = '0;
    ent_t        m_e;
    bit          m_has, m_ardy, m_mrdy;
    logic [4:0]  wlog[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aq.delete();
            mq.delete();
            m_rr_mem = 1'b0;
            e_wen    = 1'b0;
            e_addr   = '0;
            e_data   = '0;
            e_pend   = '0;
        end else begin
            m_ardy = aq.size() < DEPTH;
            m_mrdy = mq.size() < DEPTH;
            m_has  = 1'b1;
            if (aq.size() > 0 && mq.size() > 0) begin
                if (m_rr_mem) m_e = mq.pop_front();
                else          m_e = aq.pop_front();
                m_rr_mem = !m_rr_mem;
            end else if (aq.size() > 0) begin
                m_e = aq.pop_front();
            end else if (mq.size() > 0) begin
                m_e = mq.pop_front();
            end else begin
                m_has = 1'b0;
            end
            e_wen = m_has && (m_e.addr != 5'd0);
            if (e_wen) begin
                e_addr = m_e.addr;
                e_data = m_e.data;
                e_pend[m_e.addr] = 1'b0;
            end
            if (bus.alu_valid_i && m_ardy) aq.push_back('{bus.alu_addr_i, bus.alu_data_i});
            if (bus.mem_valid_i && m_mrdy) mq.push_back('{bus.mem_addr_i, bus.mem_data_i});
            if (bus.reserve_en_i && bus.reserve_addr_i != 5'd0) e_pend[bus.reserve_addr_i] = 1'b1;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("wr_en", {63'd0, bus.wr_en_o}, {63'd0, e_wen});
            if (e_wen) begin
                chk("address_3", {59'd0, bus.address_3_o}, {59'd0, e_addr});
                chk("wr_data", {32'd0, bus.wr_data_o}, {32'd0, e_data});
            end
            chk("pending", {32'd0, bus.pending_o}, {32'd0, e_pend});
            chk("alu_ready", {63'd0, bus.alu_ready_o}, {63'd0, aq.size() < DEPTH});
            chk("mem_ready", {63'd0, bus.mem_ready_o}, {63'd0, mq.size() < DEPTH});
            if (bus.wr_en_o) wlog.push_back(bus.address_3_o);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.alu_valid_i = 0; bus.alu_addr_i = '0; bus.alu_data_i = '0;
        bus.mem_valid_i = 0; bus.mem_addr_i = '0; bus.mem_data_i = '0;
        bus.reserve_en_i = 0; bus.reserve_addr_i = '0;

        // Reset state
        step();
        step();
        chk("rst_wr_en", {63'd0, bus.wr_en_o}, 64'd0);
        chk("rst_pending", {32'd0, bus.pending_o}, 64'd0);
        chk("rst_address_3", {59'd0, bus.address_3_o}, 64'd0);
        chk("rst_alu_ready", {63'd0, bus.alu_ready_o}, 64'd0);
        chk("rst_mem_ready", {63'd0, bus.mem_ready_o}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_alu_ready", {63'd0, bus.alu_ready_o}, 64'd1);
        chk("rel_mem_ready", {63'd0, bus.mem_ready_o}, 64'd1);

        // Single ALU write r5
        step();
        bus.alu_valid_i = 1; bus.alu_addr_i = 5'd5; bus.alu_data_i = 32'hDEADBEEF;
        step();
        bus.alu_valid_i = 0;
        chk("single_not_yet", {63'd0, bus.wr_en_o}, 64'd0);
        step();
        chk("single_wr_en", {63'd0, bus.wr_en_o}, 64'd1);
        chk("single_addr", {59'd0, bus.address_3_o}, 64'd5);
        chk("single_data", {32'd0, bus.wr_data_o}, 64'hDEADBEEF);
        step();
        chk("single_one_cycle", {63'd0, bus.wr_en_o}, 64'd0);

        // Both streams back to back
        wlog.delete();
        fork
            begin
                bit acc;
                int g;
                for (int i = 0; i < 8; i++) begin
                    bus.alu_valid_i = 1; bus.alu_addr_i = 5'(i + 1);
                    bus.alu_data_i = 32'hA000_0000 + 32'(i);
                    acc = 0; g = 0;
                    while (!acc && g < 40) begin acc = bus.alu_ready_o; step(); g++; end
                    chk("alu_stream_accept", {63'd0, acc}, 64'd1);
                end
                bus.alu_valid_i = 0;
            end
            begin
                bit acc;
                int g;
                for (int j = 0; j < 8; j++) begin
                    bus.mem_valid_i = 1; bus.mem_addr_i = 5'(j + 9);
                    bus.mem_data_i = 32'hB000_0000 + 32'(j);
                    acc = 0; g = 0;
                    while (!acc && g < 40) begin acc = bus.mem_ready_o; step(); g++; end
                    chk("mem_stream_accept", {63'd0, acc}, 64'd1);
                end
                bus.mem_valid_i = 0;
            end
        join
        repeat (8) step();
        chk("stream_count", 64'(wlog.size()), 64'd16);
        chk("grant0", {59'd0, wlog[0]}, 64'd1);
        chk("grant1", {59'd0, wlog[1]}, 64'd9);
        chk("grant2", {59'd0, wlog[2]}, 64'd2);
        chk("grant3", {59'd0, wlog[3]}, 64'd10);

        // Back-pressure on the load FIFO (reset puts the pointer at ALU)
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        fork
            begin
                bit acc;
                int g;
                for (int i = 0; i < 3; i++) begin
                    bus.alu_valid_i = 1; bus.alu_addr_i = 5'(24 + i);
                    bus.alu_data_i = 32'hC000_0000 + 32'(i);
                    acc = 0; g = 0;
                    while (!acc && g < 40) begin acc = bus.alu_ready_o; step(); g++; end
                    chk("bp_alu_accept", {63'd0, acc}, 64'd1);
                end
                bus.alu_valid_i = 0;
            end
            begin
                int cnt;
                int g;
                bit r;
                bit seen;
                cnt = 0; g = 0; seen = 0;
                while (cnt < 4 && g < 50) begin
                    bus.mem_valid_i = 1; bus.mem_addr_i = 5'(20 + cnt);
                    bus.mem_data_i = 32'hD000_0000 + 32'(cnt);
                    r = bus.mem_ready_o;
                    if (!r && !seen) begin
                        seen = 1;
                        chk("bp_mem_full_after", 64'(cnt), 64'd2);
                    end
                    step();
                    if (r) cnt++;
                    g++;
                end
                bus.mem_valid_i = 0;
                chk("bp_mem_saw_full", {63'd0, seen}, 64'd1);
            end
        join
        repeat (8) step();

        // Scoreboard
        bus.reserve_en_i = 1; bus.reserve_addr_i = 5'd7;
        step();
        bus.reserve_en_i = 0;
        chk("sb_reserved", {63'd0, bus.pending_o[7]}, 64'd1);
        step();
        step();
        chk("sb_held", {63'd0, bus.pending_o[7]}, 64'd1);
        bus.alu_valid_i = 1; bus.alu_addr_i = 5'd7; bus.alu_data_i = 32'h77;
        step();
        bus.alu_valid_i = 0;
        chk("sb_before_write", {63'd0, bus.pending_o[7]}, 64'd1);
        step();
        chk("sb_write_en", {63'd0, bus.wr_en_o}, 64'd1);
        chk("sb_cleared", {63'd0, bus.pending_o[7]}, 64'd0);
        bus.alu_valid_i = 1; bus.alu_addr_i = 5'd7; bus.alu_data_i = 32'h78;
        step();
        bus.alu_valid_i = 0;
        bus.reserve_en_i = 1; bus.reserve_addr_i = 5'd7;
        step();
        bus.reserve_en_i = 0;
        chk("sb_same_edge_wr", {63'd0, bus.wr_en_o}, 64'd1);
        chk("sb_set_wins", {63'd0, bus.pending_o[7]}, 64'd1);
        step();

        // Register zero
        bus.alu_valid_i = 1; bus.alu_addr_i = 5'd0; bus.alu_data_i = 32'h1234;
        step();
        bus.alu_valid_i = 0;
        step();
        chk("r0_no_write", {63'd0, bus.wr_en_o}, 64'd0);
        bus.reserve_en_i = 1; bus.reserve_addr_i = 5'd0;
        step();
        bus.reserve_en_i = 0;
        chk("r0_not_pending", {63'd0, bus.pending_o[0]}, 64'd0);
        step();

        // Asynchronous reset while both streams are busy
        bus.reserve_en_i = 1; bus.reserve_addr_i = 5'd3;
        bus.alu_valid_i = 1; bus.alu_addr_i = 5'd11; bus.alu_data_i = 32'h11;
        bus.mem_valid_i = 1; bus.mem_addr_i = 5'd12; bus.mem_data_i = 32'h12;
        step();
        bus.reserve_en_i = 0;
        repeat (4) step();
        chk("busy_wr_en", {63'd0, bus.wr_en_o}, 64'd1);
        chk("busy_pending3", {63'd0, bus.pending_o[3]}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_wr_en", {63'd0, bus.wr_en_o}, 64'd0);
        chk("async_pending", {32'd0, bus.pending_o}, 64'd0);
        chk("async_alu_ready", {63'd0, bus.alu_ready_o}, 64'd0);
        chk("async_mem_ready", {63'd0, bus.mem_ready_o}, 64'd0);
        bus.alu_valid_i = 0;
        bus.mem_valid_i = 0;
        step();
        rst = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
